// File: rtl/regfile_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : regfile_param_pkg
//  Purpose : Shared widths and clear-engine state encoding for regfile_param.
//  Rev     : 1.0
// ============================================================================
package regfile_param_pkg;

    localparam int c_RF_DATA_W = 16;
    localparam int c_RF_ADDR_W = 5;

    typedef enum logic [0:0] {
        RF_ST_CLEAR = 1'b0,
        RF_ST_READY = 1'b1
    } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : regfile_clear_fsm
//  Purpose : Post-reset sequencer that zeroes every entry, then raises ready.
//  Rev     : 1.0
// ============================================================================
module regfile_clear_fsm
    import regfile_param_pkg::*;
#(
    parameter int ADDR_W = c_RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = {ADDR_W{1'b1}};

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              w_clr_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RF_ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Wrap from the last index back to 0 lands on the CLEAR->READY edge.
            if (w_clr_active) begin
                r_clr_idx <= r_clr_idx + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_clr_active = 1'b0;
        case (r_state)
            RF_ST_CLEAR: begin
                w_clr_active = 1'b1;
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt = RF_ST_READY;
                end
            end
            RF_ST_READY: begin
                w_state_nxt = RF_ST_READY;
            end
            default: begin
                w_state_nxt = RF_ST_CLEAR;
            end
        endcase
    end

    // No clearing writes while reset is held; the sweep starts once rst drops.
    assign clr_we  = w_clr_active & ~rst;
    assign clr_idx = r_clr_idx;
    assign ready   = (r_state == RF_ST_READY);

endmodule
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
//  Module  : regfile_param
//  Purpose : 2R/1W register file with optional bypass and hardwired zero entry.
//  Rev     : 1.0
// ============================================================================
module regfile_param
    import regfile_param_pkg::*;
#(
    parameter int DATA_W   = c_RF_DATA_W,
    parameter int ADDR_W   = c_RF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] reg1_index,
    input  logic [ADDR_W-1:0] reg2_index,
    output logic [DATA_W-1:0] reg1_data,
    output logic [DATA_W-1:0] reg2_data,
    input  logic [ADDR_W-1:0] write_index,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic              ready,
    output logic              write_err
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_ready;
    logic              w_user_we;
    logic              r_write_err;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk     (clk),
        .rst     (rst),
        .clr_we  (w_clr_we),
        .clr_idx (w_clr_idx),
        .ready   (w_ready)
    );

    // Writes to entry 0 are dropped silently when it is hardwired to zero.
    assign w_user_we = w_ready & write_en &
                       ~((ZERO_REG != 0) && (write_index == '0));

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_user_we) begin
            r_mem[write_index] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_err <= 1'b0;
        end else begin
            r_write_err <= write_en & ~w_ready;
        end
    end

    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic              rdy,
        input logic              wen,
        input logic [ADDR_W-1:0] widx,
        input logic [DATA_W-1:0] wdata
    );
        if (!rdy) begin
            return '0;
        end else if ((ZERO_REG != 0) && (idx == '0)) begin
            return '0;
        end else if ((BYPASS != 0) && wen && (idx == widx)) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    always_comb begin
        reg1_data = f_read(reg1_index, r_mem[reg1_index], w_ready,
                           write_en, write_index, write_data);
        reg2_data = f_read(reg2_index, r_mem[reg2_index], w_ready,
                           write_en, write_index, write_data);
    end

    assign ready     = w_ready;
    assign write_err = r_write_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
//  Module  : tb_regfile_param
//  Purpose : Directed bench over default, no-bypass and zero-register variants.
//  Rev     : 1.0
// ============================================================================
module tb_regfile_param;

    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] reg1_index, reg2_index, write_index;
    logic [DW-1:0] write_data;
    logic          write_en;

    logic [DW-1:0] d_r1, d_r2, n_r1, n_r2, z_r1, z_r2;
    logic          d_rdy, n_rdy, z_rdy, d_err, n_err, z_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .reg1_index(reg1_index), .reg2_index(reg2_index),
        .reg1_data(d_r1), .reg2_data(d_r2), .write_index(write_index),
        .write_data(write_data), .write_en(write_en), .ready(d_rdy), .write_err(d_err));

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .reg1_index(reg1_index), .reg2_index(reg2_index),
        .reg1_data(n_r1), .reg2_data(n_r2), .write_index(write_index),
        .write_data(write_data), .write_en(write_en), .ready(n_rdy), .write_err(n_err));

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .clk(clk), .rst(rst), .reg1_index(reg1_index), .reg2_index(reg2_index),
        .reg1_data(z_r1), .reg2_data(z_r2), .write_index(write_index),
        .write_data(write_data), .write_en(write_en), .ready(z_rdy), .write_err(z_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rst has just dropped: ready must stay low for 32 samples, then be high.
    task automatic check_clear(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_rdy_lo"}, {29'd0, d_rdy, n_rdy, z_rdy}, 32'd0);
            tick();
        end
        chk({tag, "_rdy_hi"}, {29'd0, d_rdy, n_rdy, z_rdy}, 32'h7);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            reg1_index = AW'(i);
            reg2_index = AW'(31 - i);
            #1;
            chk({tag, "_d"}, {d_r1, d_r2}, 32'd0);
            chk({tag, "_n"}, {n_r1, n_r2}, 32'd0);
            chk({tag, "_z"}, {z_r1, z_r2}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; write_en = 1'b0; write_index = '0; write_data = '0;
        reg1_index = '0; reg2_index = '0;

        // 1. reset and full clear
        tick(); tick();
        chk("rst_ready", {29'd0, d_rdy, n_rdy, z_rdy}, 32'd0);
        chk("rst_werr",  {29'd0, d_err, n_err, z_err}, 32'd0);
        chk("rst_read",  {d_r1, d_r2}, 32'd0);
        rst = 1'b0;
        check_clear("clr1");
        check_all_zero("zero1");

        // 2. basic write/read
        write_index = 5'd7; write_data = 16'hBEEF; write_en = 1'b1;
        tick();
        write_en = 1'b0; reg1_index = 5'd7; reg2_index = 5'd8;
        #1;
        chk("wr7_d", {d_r1, d_r2}, {16'hBEEF, 16'h0000});
        chk("wr7_n", {n_r1, n_r2}, {16'hBEEF, 16'h0000});
        chk("wr_ok_err", {29'd0, d_err, n_err, z_err}, 32'd0);

        // 3. bypass
        reg2_index = 5'd3; write_index = 5'd3; write_data = 16'h1234; write_en = 1'b1;
        #1;
        chk("byp_same", d_r2, 16'h1234);
        chk("nobyp_same", n_r2, 16'h0000);
        tick();
        write_en = 1'b0;
        #1;
        chk("nobyp_next", n_r2, 16'h1234);
        chk("byp_next", d_r2, 16'h1234);

        // 4. zero register
        reg1_index = 5'd0; write_index = 5'd0; write_data = 16'hFFFF; write_en = 1'b1;
        #1;
        chk("zr_same", z_r1, 16'h0000);
        chk("nzr_byp", d_r1, 16'hFFFF);
        tick();
        write_en = 1'b0;
        #1;
        chk("zr_next", z_r1, 16'h0000);
        chk("zr_werr", {31'd0, z_err}, 32'd0);
        chk("nzr_next", {d_r1, n_r1}, {16'hFFFF, 16'hFFFF});

        // top index boundary
        write_index = 5'd31; write_data = 16'h5A5A; write_en = 1'b1;
        tick();
        write_en = 1'b0; reg2_index = 5'd31;
        #1;
        chk("wr31", {d_r2, z_r2}, {16'h5A5A, 16'h5A5A});

        // 5. write during clear
        rst = 1'b1;
        tick();
        chk("rst2_ready", {29'd0, d_rdy, n_rdy, z_rdy}, 32'd0);
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        write_index = 5'd20; write_data = 16'hAAAA; write_en = 1'b1;
        #1;
        chk("clr_werr_pre", {29'd0, d_err, n_err, z_err}, 32'd0);
        chk("clr_read", {d_r1, z_r1}, 32'd0);
        tick();
        write_en = 1'b0;
        #1;
        chk("clr_werr_hi", {29'd0, d_err, n_err, z_err}, 32'h7);
        tick();
        chk("clr_werr_lo", {29'd0, d_err, n_err, z_err}, 32'd0);

        // 6. reset at clear cycle 10
        for (int c = 7; c <= 9; c++) tick();
        chk("mid_ready", {29'd0, d_rdy, n_rdy, z_rdy}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_clear("clr2");
        check_all_zero("zero2");
        reg1_index = 5'd20; reg2_index = 5'd7;
        #1;
        chk("idx20_idx7", {d_r1, d_r2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
